// File: rtl/spi_xfer_sched_pkg.sv
// Shared definitions for the SPI transfer scheduler: core register map,
// CTRL/STAT bit positions and the sequencer state encoding.
package spi_xfer_sched_pkg;

    localparam logic [31:0] OFF_DATA = 32'h0000_0000;
    localparam logic [31:0] OFF_CTRL = 32'h0000_0004;
    localparam logic [31:0] OFF_STAT = 32'h0000_0008;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_CPOL = 1;
    localparam int CTRL_CPHA = 2;
    localparam int CTRL_SEL  = 3;

    localparam int STAT_BUSY = 0;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD  = 4'd1,
        ST_START = 4'd2,
        ST_ARM   = 4'd3,
        ST_BUSY  = 4'd4,
        ST_READ  = 4'd5,
        ST_NEXT  = 4'd6,
        ST_DONE  = 4'd7,
        ST_ABORT = 4'd8
    } state_e;

    // mode = {sel, cpha, cpol}; enable is always set for a byte start
    function automatic logic [31:0] ctrl_word(input logic [2:0] mode);
        logic [31:0] w;
        w            = 32'h0000_0000;
        w[CTRL_EN]   = 1'b1;
        w[CTRL_CPOL] = mode[0];
        w[CTRL_CPHA] = mode[1];
        w[CTRL_SEL]  = mode[2];
        return w;
    endfunction

endpackage

// File: rtl/spi_xfer_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the winner only when
// the grant is actually accepted.
module spi_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       gnt_idx,
    output logic       any_req
);

    logic ptr_q;
    logic ptr_d;

    assign any_req = |req;
    assign gnt_idx = req[ptr_q] ? ptr_q : ~ptr_q;

    // Pointer update: favour the other requester after an accepted grant
    always_comb begin
        ptr_d = ptr_q;
        if (accept && any_req) begin
            ptr_d = ~gnt_idx;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spi_xfer_sched.sv
// Owns the SPI core register port: grants one requester per transaction and
// walks each byte through DATA load, CTRL start, STAT busy tracking and readback.
module spi_xfer_sched
    import spi_xfer_sched_pkg::*;
#(
    parameter logic [31:0] SPI_BASE     = 32'hffff_0010,
    parameter int          ARM_TIMEOUT  = 64,
    parameter int          BUSY_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_len,
    input  logic [5:0]  req_mode,
    input  logic [1:0]  tx_valid,
    output logic [1:0]  tx_ready,
    input  logic [15:0] tx_data,
    output logic [1:0]  rx_valid,
    output logic [7:0]  rx_data,
    output logic [1:0]  done,
    output logic        err,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = $clog2((ARM_TIMEOUT > BUSY_TIMEOUT) ? ARM_TIMEOUT : BUSY_TIMEOUT) + 1;
    localparam logic [31:0] ADDR_DATA = SPI_BASE + OFF_DATA;
    localparam logic [31:0] ADDR_CTRL = SPI_BASE + OFF_CTRL;
    localparam logic [31:0] ADDR_STAT = SPI_BASE + OFF_STAT;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic [7:0]       rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_phase_q, rd_phase_d;
    logic             abort_q, abort_d;
    logic [1:0]       req_ready_q, req_ready_d;
    logic [1:0]       tx_ready_q, tx_ready_d;
    logic [1:0]       rx_valid_q, rx_valid_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [1:0]       done_q, done_d;
    logic             err_q, err_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;

    logic       gnt_s, any_req_s, accept_s, busy_s;
    logic [1:0] own_oh_s;
    logic [7:0] tx_byte_s, rem_dec_s;
    logic       unused_rdata_s;

    spi_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .accept  (accept_s),
        .gnt_idx (gnt_s),
        .any_req (any_req_s)
    );

    // STAT is only meaningful while no write is on the bus
    assign busy_s         = bus_rdata[STAT_BUSY] & ~bus_we_q;
    assign own_oh_s       = owner_q ? 2'b10 : 2'b01;
    assign tx_byte_s      = owner_q ? tx_data[15:8] : tx_data[7:0];
    assign rem_dec_s      = (rem_q != 8'd0) ? (rem_q - 8'd1) : 8'd0;
    assign unused_rdata_s = ^bus_rdata[31:8];

    // Sequencer next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rem_d       = rem_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        rd_phase_d  = rd_phase_q;
        abort_d     = abort_q;
        accept_s    = 1'b0;
        req_ready_d = 2'b00;
        tx_ready_d  = 2'b00;
        rx_valid_d  = 2'b00;
        rx_data_d   = rx_data_q;
        done_d      = 2'b00;
        err_d       = 1'b0;
        bus_we_d    = 1'b0;
        bus_addr_d  = ADDR_STAT;
        bus_wdata_d = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    accept_s    = 1'b1;
                    owner_d     = gnt_s;
                    req_ready_d = gnt_s ? 2'b10 : 2'b01;
                    rem_d       = gnt_s ? req_len[15:8] : req_len[7:0];
                    mode_d      = gnt_s ? req_mode[5:3] : req_mode[2:0];
                    abort_d     = 1'b0;
                    state_d     = (rem_d == 8'd0) ? ST_DONE : ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (tx_valid[owner_q]) begin
                    tx_ready_d  = own_oh_s;
                    bus_we_d    = 1'b1;
                    bus_addr_d  = ADDR_DATA;
                    bus_wdata_d = {24'h00_0000, tx_byte_s};
                    state_d     = ST_START;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_START: begin
                bus_we_d    = 1'b1;
                bus_addr_d  = ADDR_CTRL;
                bus_wdata_d = ctrl_word(mode_q);
                cnt_d       = {CNT_W{1'b0}};
                state_d     = ST_ARM;
            end
            ST_ARM: begin
                if (busy_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_BUSY;
                end else if (cnt_q == CNT_W'(ARM_TIMEOUT - 1)) begin
                    state_d = ST_ABORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BUSY: begin
                if (!busy_s) begin
                    rd_phase_d = 1'b0;
                    state_d    = ST_READ;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    state_d = ST_ABORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_READ: begin
                bus_addr_d = ADDR_DATA;
                if (!rd_phase_q) begin
                    rd_phase_d = 1'b1;
                end else begin
                    rd_phase_d = 1'b0;
                    rx_valid_d = own_oh_s;
                    rx_data_d  = bus_rdata[7:0];
                    state_d    = ST_NEXT;
                end
            end
            ST_NEXT: begin
                rem_d   = rem_dec_s;
                state_d = (rem_dec_s == 8'd0) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                done_d  = own_oh_s;
                err_d   = abort_q;
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                bus_we_d    = 1'b1;
                bus_addr_d  = ADDR_CTRL;
                bus_wdata_d = 32'h0000_0000;
                abort_d     = 1'b1;
                state_d     = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            rem_q       <= 8'd0;
            mode_q      <= 3'd0;
            cnt_q       <= {CNT_W{1'b0}};
            rd_phase_q  <= 1'b0;
            abort_q     <= 1'b0;
            req_ready_q <= 2'b00;
            tx_ready_q  <= 2'b00;
            rx_valid_q  <= 2'b00;
            rx_data_q   <= 8'h00;
            done_q      <= 2'b00;
            err_q       <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= ADDR_STAT;
            bus_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rem_q       <= rem_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            rd_phase_q  <= rd_phase_d;
            abort_q     <= abort_d;
            req_ready_q <= req_ready_d;
            tx_ready_q  <= tx_ready_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign tx_ready  = tx_ready_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign done      = done_q;
    assign err       = err_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule
